// File: rtl/sigmoid_lut_arbiter.sv
// sigmoid_lut_arbiter: round-robin sharing of one sigmoid LUT ROM with a credit-limited, tagged response buffer
module sigmoid_lut_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int IN_W      = 16,
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 10,
  parameter int SHIFT     = 2,
  parameter int LUT_LAT   = 1,
  parameter int OUT_DEPTH = 2,
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic [NUM_REQ-1:0]      i_req_valid,
  output logic [NUM_REQ-1:0]      o_req_ready,
  input  logic [NUM_REQ*IN_W-1:0] i_req_x,
  output logic                    o_lut_en,
  output logic [ADDR_W-1:0]       o_lut_addr,
  input  logic [DATA_W-1:0]       i_lut_data,
  output logic                    o_rsp_valid,
  input  logic                    i_rsp_ready,
  output logic [DATA_W-1:0]       o_rsp_data,
  output logic [IDW-1:0]          o_rsp_id,
  output logic                    o_busy
);
  localparam int PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int CW = $clog2(OUT_DEPTH + 1);
  localparam logic signed [IN_W:0] BIAS = (IN_W+1)'(2 ** (ADDR_W - 1));
  localparam logic signed [IN_W:0] AMAX = (IN_W+1)'(2 ** ADDR_W - 1);
  logic                          r_live;
  logic [IDW-1:0]                r_ptr;
  logic [LUT_LAT-1:0]            r_vld;
  logic [LUT_LAT-1:0][IDW-1:0]   r_ids;
  logic [DATA_W-1:0]             r_data [OUT_DEPTH];
  logic [IDW-1:0]                r_bid  [OUT_DEPTH];
  logic [PW-1:0]                 r_wp, r_rp;
  logic [CW-1:0]                 r_cnt;
  logic                          w_en, w_found, w_gnt, w_ok, w_pop, w_push;
  logic [NUM_REQ-1:0]            w_rot;
  logic [IDW-1:0]                w_gid;
  logic [IN_W-1:0]               w_x;
  logic signed [IN_W:0]          w_t, w_a;
  int                            w_infl;
  // outputs stay quiet while reset is low and for one cycle after release
  assign w_en = i_reset & r_live;
  assign w_rot = NUM_REQ'({i_req_valid, i_req_valid} >> r_ptr);
  always_comb begin
    w_found = 1'b0;
    w_gid = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_found && w_rot[k]) begin
        w_found = 1'b1;
        w_gid = IDW'((int'(r_ptr) + k) % NUM_REQ);
      end
    end
  end
  always_comb begin
    w_x = '0;
    for (int k = 0; k < NUM_REQ; k++) w_x = (w_gid == IDW'(k)) ? i_req_x[k*IN_W +: IN_W] : w_x;
  end
  always_comb begin
    w_infl = 0;
    for (int k = 0; k < LUT_LAT; k++) w_infl = w_infl + int'(r_vld[k]);
  end
  assign w_pop = o_rsp_valid & i_rsp_ready;
  assign w_push = r_vld[LUT_LAT-1];
  assign w_ok = (int'(r_cnt) + w_infl - int'(w_pop)) < OUT_DEPTH;
  assign w_gnt = w_en & w_found & w_ok;
  assign w_t = $signed({w_x[IN_W-1], w_x}) >>> SHIFT;
  assign w_a = w_t + BIAS;
  assign o_req_ready = w_gnt ? (NUM_REQ'(1) << w_gid) : '0;
  assign o_lut_en = w_gnt;
  assign o_lut_addr = !w_gnt ? '0 : w_a[IN_W] ? '0 : (w_a > AMAX) ? '1 : w_a[ADDR_W-1:0];
  assign o_rsp_valid = w_en & (r_cnt != '0);
  assign o_rsp_data = o_rsp_valid ? r_data[r_rp] : '0;
  assign o_rsp_id = o_rsp_valid ? r_bid[r_rp] : '0;
  assign o_busy = w_en & ((|r_vld) | (r_cnt != '0));
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_live <= 1'b0;
      r_ptr <= '0;
      r_vld <= '0;
      r_ids <= '0;
      r_wp <= '0;
      r_rp <= '0;
      r_cnt <= '0;
    end else begin
      r_live <= 1'b1;
      if (w_gnt) r_ptr <= (w_gid == IDW'(NUM_REQ - 1)) ? '0 : w_gid + IDW'(1);
      r_vld[0] <= w_gnt;
      r_ids[0] <= w_gid;
      for (int i = 1; i < LUT_LAT; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_ids[i] <= r_ids[i-1];
      end
      if (w_push) r_wp <= (r_wp == PW'(OUT_DEPTH - 1)) ? '0 : r_wp + PW'(1);
      if (w_pop) r_rp <= (r_rp == PW'(OUT_DEPTH - 1)) ? '0 : r_rp + PW'(1);
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end
  always_ff @(posedge i_clock) begin
    if (w_push) begin
      r_data[r_wp] <= i_lut_data;
      r_bid[r_wp] <= r_ids[LUT_LAT-1];
    end
  end
endmodule

// File: tb/tb_sigmoid_lut_arbiter.sv
// tb_sigmoid_lut_arbiter: directed vectors for the sigmoid LUT arbiter with a behavioural 1-cycle ROM
module tb_sigmoid_lut_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  v;
  logic [3:0]  rdy;
  logic [63:0] x;
  logic        en;
  logic [9:0]  addr;
  logic [9:0]  ldata = '0;
  logic        rv;
  logic        rr;
  logic [9:0]  rdata;
  logic [1:0]  rid;
  logic        busy;
  int          n_chk = 0;
  int          n_fail = 0;
  logic [15:0] sx [4];
  int          sa [4];
  int          g;
  int          id;

  sigmoid_lut_arbiter dut (
    .i_clock(clk), .i_reset(rst), .i_req_valid(v), .o_req_ready(rdy), .i_req_x(x),
    .o_lut_en(en), .o_lut_addr(addr), .i_lut_data(ldata), .o_rsp_valid(rv),
    .i_rsp_ready(rr), .o_rsp_data(rdata), .o_rsp_id(rid), .o_busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] rom(input int a);
    logic [9:0] w;
    w = 10'(a);
    return w ^ 10'h2A5;
  endfunction

  always @(posedge clk) if (en) ldata <= rom(int'(addr));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  initial begin
    rst = 1'b0; v = 4'h0; x = '0; rr = 1'b0;
    sx[0] = 16'h7FFF; sa[0] = 1023;
    sx[1] = 16'h8000; sa[1] = 0;
    sx[2] = 16'hFFFC; sa[2] = 511;
    sx[3] = 16'h0008; sa[3] = 514;
    tick;
    v = 4'hF;
    tick;
    #1;
    chk("rst_ready", int'(rdy), 0);
    chk("rst_en", int'(en), 0);
    chk("rst_addr", int'(addr), 0);
    chk("rst_rv", int'(rv), 0);
    chk("rst_rdata", int'(rdata), 0);
    chk("rst_rid", int'(rid), 0);
    chk("rst_busy", int'(busy), 0);
    tick;
    rst = 1'b1;
    #1;
    chk("post_rst_ready", int'(rdy), 0);
    chk("post_rst_en", int'(en), 0);
    v = 4'h0;
    tick;
    // single request at zero input
    v = 4'h1; rr = 1'b1;
    #1;
    chk("t1_ready", int'(rdy), 1);
    chk("t1_en", int'(en), 1);
    chk("t1_addr", int'(addr), 512);
    tick;
    v = 4'h0;
    #1;
    chk("t1_rv_c1", int'(rv), 0);
    chk("t1_busy_c1", int'(busy), 1);
    chk("t1_addr_idle", int'(addr), 0);
    tick;
    #1;
    chk("t1_rv_c2", int'(rv), 1);
    chk("t1_rid_c2", int'(rid), 0);
    chk("t1_rdata_c2", int'(rdata), int'(rom(512)));
    tick;
    #1;
    chk("t1_rv_c3", int'(rv), 0);
    chk("t1_busy_c3", int'(busy), 0);
    tick;
    // saturation corners through requester 0
    for (int i = 0; i < 4; i++) begin
      v = 4'h1;
      x = {48'd0, sx[i]};
      #1;
      chk("t2_sat_addr", int'(addr), sa[i]);
      tick;
    end
    v = 4'h0;
    tick; tick; tick;
    // round-robin from pointer 1, distinct address per requester
    x = {16'd12, 16'd8, 16'd4, 16'd0};
    v = 4'hF;
    for (int c = 0; c < 10; c++) begin
      if (c == 8) v = 4'h0;
      #1;
      if (c < 8) begin
        g = (1 + c) % 4;
        chk("t3_grant", int'(rdy), 1 << g);
        chk("t3_addr", int'(addr), 512 + g);
      end
      if (c >= 2) begin
        id = (c - 1) % 4;
        chk("t3_rv", int'(rv), 1);
        chk("t3_rid", int'(rid), id);
        chk("t3_rdata", int'(rdata), int'(rom(512 + id)));
      end
      tick;
    end
    #1;
    chk("t3_idle", int'(busy), 0);
    tick;
    // reset while a read is in flight
    v = 4'hF;
    #1;
    chk("t5_grant", int'(rdy), 2);
    tick;
    rst = 1'b0;
    #1;
    chk("t5_rv_in_rst", int'(rv), 0);
    chk("t5_busy_in_rst", int'(busy), 0);
    tick;
    rst = 1'b1;
    #1;
    chk("t5_rv_after", int'(rv), 0);
    chk("t5_busy_after", int'(busy), 0);
    chk("t5_ready_after", int'(rdy), 0);
    tick;
    // backpressure: pointer restarted at 0
    rr = 1'b0;
    #1;
    chk("t4_g0", int'(rdy), 1);
    tick;
    #1;
    chk("t4_g1", int'(rdy), 2);
    tick;
    #1;
    chk("t4_stall_c2", int'(rdy), 0);
    chk("t4_rv_c2", int'(rv), 1);
    chk("t4_rid_c2", int'(rid), 0);
    tick;
    #1;
    chk("t4_stall_c3", int'(rdy), 0);
    chk("t4_rv_c3", int'(rv), 1);
    chk("t4_rid_c3", int'(rid), 0);
    chk("t4_rdata_c3", int'(rdata), int'(rom(512)));
    chk("t4_busy_c3", int'(busy), 1);
    tick;
    rr = 1'b1;
    #1;
    chk("t4_pop_grant", int'(rdy), 4);
    chk("t4_pop_rid", int'(rid), 0);
    tick;
    rr = 1'b0;
    #1;
    chk("t4_stall_c5", int'(rdy), 0);
    chk("t4_rid_c5", int'(rid), 1);
    tick;
    rr = 1'b1; v = 4'h0;
    #1;
    chk("t4_rid_c6", int'(rid), 1);
    chk("t4_rdata_c6", int'(rdata), int'(rom(513)));
    tick;
    #1;
    chk("t4_rid_c7", int'(rid), 2);
    chk("t4_rdata_c7", int'(rdata), int'(rom(514)));
    tick;
    #1;
    chk("t4_rv_c8", int'(rv), 0);
    chk("t4_busy_c8", int'(busy), 0);
    tick;
    // sparse requests with wrap from pointer 3
    v = 4'h5;
    #1;
    chk("t6_wrap_g0", int'(rdy), 1);
    tick;
    #1;
    chk("t6_g2", int'(rdy), 4);
    tick;
    #1;
    chk("t6_g0_again", int'(rdy), 1);
    tick;
    v = 4'h0;
    tick; tick; tick;
    #1;
    chk("t6_idle", int'(busy), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
